// File: rtl/kgp_pkg.sv
// Shared types and constants for the KGP-RISC pipeline.
package kgp_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 4;

    // Decoded control bundle carried down the pipeline.
    typedef struct packed {
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               memtoreg;
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by ID.
module hazard_detect #(
    parameter int REG_ADDR_W = kgp_pkg::REG_ADDR_W
) (
    input  logic                  ex_valid,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    output logic                  hazard
);

    logic rs_match;
    logic rt_match;

    // Only real source operands can create a dependency; r0 never does.
    always_comb begin
        rs_match = id_uses_rs && (id_rs == ex_rd);
        rt_match = id_uses_rt && (id_rt == ex_rd);
        hazard   = ex_valid && ex_memread && (ex_rd != '0) && id_valid
                   && (rs_match || rt_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and stall counting.
module id_ex_stage #(
    parameter int DATA_W     = kgp_pkg::DATA_W,
    parameter int REG_ADDR_W = kgp_pkg::REG_ADDR_W,
    parameter int ALUOP_W    = kgp_pkg::ALUOP_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  if_id_valid,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic [REG_ADDR_W-1:0] if_id_rd,
    input  logic                  if_id_uses_rs,
    input  logic                  if_id_uses_rt,
    input  logic [DATA_W-1:0]     if_id_rs_data,
    input  logic [DATA_W-1:0]     if_id_rt_data,
    input  logic [DATA_W-1:0]     if_id_imm,
    input  logic [DATA_W-1:0]     if_id_pc,
    input  logic                  if_id_regwrite,
    input  logic                  if_id_memread,
    input  logic                  if_id_memwrite,
    input  logic                  if_id_memtoreg,
    input  logic                  if_id_alusrc,
    input  logic [ALUOP_W-1:0]    if_id_aluop,
    output logic                  stall,
    output logic                  id_ex_valid,
    output logic [REG_ADDR_W-1:0] id_ex_rs,
    output logic [REG_ADDR_W-1:0] id_ex_rt,
    output logic [REG_ADDR_W-1:0] id_ex_rd,
    output logic [DATA_W-1:0]     id_ex_rs_data,
    output logic [DATA_W-1:0]     id_ex_rt_data,
    output logic [DATA_W-1:0]     id_ex_imm,
    output logic [DATA_W-1:0]     id_ex_pc,
    output logic                  id_ex_regwrite,
    output logic                  id_ex_memread,
    output logic                  id_ex_memwrite,
    output logic                  id_ex_memtoreg,
    output logic                  id_ex_alusrc,
    output logic [ALUOP_W-1:0]    id_ex_aluop,
    output logic [CNT_W-1:0]      stall_count
);

    import kgp_pkg::*;

    logic                  valid_q;
    ctrl_t                 ctrl_q;
    logic [REG_ADDR_W-1:0] rs_q, rt_q, rd_q;
    logic [DATA_W-1:0]     rs_data_q, rt_data_q, imm_q, pc_q;
    logic [CNT_W-1:0]      stall_count_q;

    logic                  hazard;
    ctrl_t                 ld_ctrl;
    logic [REG_ADDR_W-1:0] ld_rs, ld_rt;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .ex_valid   (valid_q),
        .ex_memread (ctrl_q.memread),
        .ex_rd      (rd_q),
        .id_valid   (if_id_valid),
        .id_rs      (if_id_rs),
        .id_rt      (if_id_rt),
        .id_uses_rs (if_id_uses_rs),
        .id_uses_rt (if_id_uses_rt),
        .hazard     (hazard)
    );

    // Qualify incoming control with valid, block r0 writes, hide unused operands.
    always_comb begin
        ld_ctrl          = CTRL_BUBBLE;
        ld_ctrl.regwrite = if_id_regwrite && if_id_valid && (if_id_rd != '0);
        ld_ctrl.memread  = if_id_memread  && if_id_valid;
        ld_ctrl.memwrite = if_id_memwrite && if_id_valid;
        ld_ctrl.memtoreg = if_id_memtoreg && if_id_valid;
        ld_ctrl.alusrc   = if_id_alusrc   && if_id_valid;
        ld_ctrl.aluop    = if_id_valid ? if_id_aluop : '0;
        ld_rs            = if_id_uses_rs ? if_id_rs : '0;
        ld_rt            = if_id_uses_rt ? if_id_rt : '0;
    end

    // A flush throws away the ID instruction, so the front end need not hold.
    always_comb begin
        stall = hazard && !flush;
    end

    // Pipeline register: flush > hold > hazard bubble > normal load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_BUBBLE;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
        end else if (flush || (!hold && hazard)) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_BUBBLE;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
        end else if (!hold) begin
            valid_q   <= if_id_valid;
            ctrl_q    <= ld_ctrl;
            rs_q      <= ld_rs;
            rt_q      <= ld_rt;
            rd_q      <= if_id_rd;
            rs_data_q <= if_id_rs_data;
            rt_data_q <= if_id_rt_data;
            imm_q     <= if_id_imm;
            pc_q      <= if_id_pc;
        end
    end

    // Count inserted load-use bubbles, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
        end else if (hazard && !flush && !hold && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + CNT_W'(1);
        end
    end

    // Drive outputs straight from the register so EX and forwarding see them directly.
    always_comb begin
        id_ex_valid    = valid_q;
        id_ex_rs       = rs_q;
        id_ex_rt       = rt_q;
        id_ex_rd       = rd_q;
        id_ex_rs_data  = rs_data_q;
        id_ex_rt_data  = rt_data_q;
        id_ex_imm      = imm_q;
        id_ex_pc       = pc_q;
        id_ex_regwrite = ctrl_q.regwrite;
        id_ex_memread  = ctrl_q.memread;
        id_ex_memwrite = ctrl_q.memwrite;
        id_ex_memtoreg = ctrl_q.memtoreg;
        id_ex_alusrc   = ctrl_q.alusrc;
        id_ex_aluop    = ctrl_q.aluop;
        stall_count    = stall_count_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for the ID/EX stage.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold, flush;
    logic        if_id_valid;
    logic [4:0]  if_id_rs, if_id_rt, if_id_rd;
    logic        if_id_uses_rs, if_id_uses_rt;
    logic [31:0] if_id_rs_data, if_id_rt_data, if_id_imm, if_id_pc;
    logic        if_id_regwrite, if_id_memread, if_id_memwrite, if_id_memtoreg, if_id_alusrc;
    logic [3:0]  if_id_aluop;
    logic        stall;
    logic        id_ex_valid;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
    logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_pc;
    logic        id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg, id_ex_alusrc;
    logic [3:0]  id_ex_aluop;
    logic [15:0] stall_count;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data, imm, pc;
        logic        regwrite, memread, memwrite, memtoreg, alusrc;
        logic [3:0]  aluop;
        logic [15:0] count;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    exp_t m;
    exp_t sb[$];

    always #5 clk = ~clk;

    id_ex_stage #(
        .DATA_W     (32),
        .REG_ADDR_W (5),
        .ALUOP_W    (4),
        .CNT_W      (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hold           (hold),
        .flush          (flush),
        .if_id_valid    (if_id_valid),
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt),
        .if_id_rd       (if_id_rd),
        .if_id_uses_rs  (if_id_uses_rs),
        .if_id_uses_rt  (if_id_uses_rt),
        .if_id_rs_data  (if_id_rs_data),
        .if_id_rt_data  (if_id_rt_data),
        .if_id_imm      (if_id_imm),
        .if_id_pc       (if_id_pc),
        .if_id_regwrite (if_id_regwrite),
        .if_id_memread  (if_id_memread),
        .if_id_memwrite (if_id_memwrite),
        .if_id_memtoreg (if_id_memtoreg),
        .if_id_alusrc   (if_id_alusrc),
        .if_id_aluop    (if_id_aluop),
        .stall          (stall),
        .id_ex_valid    (id_ex_valid),
        .id_ex_rs       (id_ex_rs),
        .id_ex_rt       (id_ex_rt),
        .id_ex_rd       (id_ex_rd),
        .id_ex_rs_data  (id_ex_rs_data),
        .id_ex_rt_data  (id_ex_rt_data),
        .id_ex_imm      (id_ex_imm),
        .id_ex_pc       (id_ex_pc),
        .id_ex_regwrite (id_ex_regwrite),
        .id_ex_memread  (id_ex_memread),
        .id_ex_memwrite (id_ex_memwrite),
        .id_ex_memtoreg (id_ex_memtoreg),
        .id_ex_alusrc   (id_ex_alusrc),
        .id_ex_aluop    (id_ex_aluop),
        .stall_count    (stall_count)
    );

    function automatic exp_t obs();
        exp_t o;
        o.valid    = id_ex_valid;
        o.rs       = id_ex_rs;
        o.rt       = id_ex_rt;
        o.rd       = id_ex_rd;
        o.rs_data  = id_ex_rs_data;
        o.rt_data  = id_ex_rt_data;
        o.imm      = id_ex_imm;
        o.pc       = id_ex_pc;
        o.regwrite = id_ex_regwrite;
        o.memread  = id_ex_memread;
        o.memwrite = id_ex_memwrite;
        o.memtoreg = id_ex_memtoreg;
        o.alusrc   = id_ex_alusrc;
        o.aluop    = id_ex_aluop;
        o.count    = stall_count;
        return o;
    endfunction

    task automatic check(input string tag, input exp_t o, input exp_t e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic check_bit(input string tag, input logic o, input logic e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw,
                         input logic mtr, input logic asrc, input logic [3:0] aop);
        if_id_valid    = v;
        if_id_rs       = rs;
        if_id_uses_rs  = urs;
        if_id_rt       = rt;
        if_id_uses_rt  = urt;
        if_id_rd       = rd;
        if_id_regwrite = rw;
        if_id_memread  = mr;
        if_id_memwrite = mw;
        if_id_memtoreg = mtr;
        if_id_alusrc   = asrc;
        if_id_aluop    = aop;
        if_id_rs_data  = $urandom;
        if_id_rt_data  = $urandom;
        if_id_imm      = $urandom;
        if_id_pc       = $urandom & 32'hFFFF_FFFC;
    endtask

    // Reference behaviour: compute next ID/EX contents, queue them, compare after the edge.
    task automatic step(input string tag);
        exp_t nxt;
        logic hz;
        #1;
        hz = m.valid && m.memread && (m.rd != 5'd0) && if_id_valid &&
             ((if_id_uses_rs && if_id_rs == m.rd) || (if_id_uses_rt && if_id_rt == m.rd));
        check_bit({tag, "_stall"}, stall, hz && !flush);
        nxt = m;
        if (flush || (!hold && hz)) begin
            nxt       = '0;
            nxt.count = m.count;
        end else if (!hold) begin
            nxt.valid    = if_id_valid;
            nxt.rs       = if_id_uses_rs ? if_id_rs : 5'd0;
            nxt.rt       = if_id_uses_rt ? if_id_rt : 5'd0;
            nxt.rd       = if_id_rd;
            nxt.rs_data  = if_id_rs_data;
            nxt.rt_data  = if_id_rt_data;
            nxt.imm      = if_id_imm;
            nxt.pc       = if_id_pc;
            nxt.regwrite = if_id_regwrite && if_id_valid && (if_id_rd != 5'd0);
            nxt.memread  = if_id_memread && if_id_valid;
            nxt.memwrite = if_id_memwrite && if_id_valid;
            nxt.memtoreg = if_id_memtoreg && if_id_valid;
            nxt.alusrc   = if_id_alusrc && if_id_valid;
            nxt.aluop    = if_id_valid ? if_id_aluop : 4'd0;
        end
        if (hz && !flush && !hold && m.count != 16'hFFFF)
            nxt.count = m.count + 16'd1;
        sb.push_back(nxt);
        m = nxt;
        @(posedge clk);
        #1;
        check(tag, obs(), sb.pop_front());
    endtask

    initial begin
        rst   = 1'b1;
        hold  = 1'b0;
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
        m = '0;
        #3;
        check("reset_state", obs(), '0);
        check_bit("reset_stall", stall, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Load-use: lw r5 then add reading r5
        drive(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 1, 1, 4'd2);
        step("lw_r5");
        drive(1, 5'd5, 1, 5'd6, 1, 5'd8, 1, 0, 0, 0, 0, 4'd3);
        step("lu_bubble");
        check_bit("lu_count1", stall_count == 16'd1, 1'b1);
        step("lu_add_load");
        check_bit("lu_rs5", id_ex_rs == 5'd5, 1'b1);

        // r0 destination never causes a hazard
        drive(1, 5'd2, 1, 5'd0, 0, 5'd0, 1, 1, 0, 1, 1, 4'd2);
        step("lw_r0");
        drive(1, 5'd0, 1, 5'd3, 1, 5'd9, 1, 0, 0, 0, 0, 4'd1);
        step("add_r0_nohz");

        // Unused rt operand does not match
        drive(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 0, 1, 1, 4'd2);
        step("lw_r7");
        drive(1, 5'd2, 1, 5'd7, 0, 5'd10, 1, 0, 0, 0, 1, 4'd4);
        step("unused_rt");

        // Flush wins over hazard; counter untouched
        drive(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 1, 1, 4'd2);
        step("lw_r5_b");
        drive(1, 5'd5, 1, 5'd5, 1, 5'd11, 1, 0, 0, 0, 0, 4'd3);
        flush = 1'b1;
        step("flush_hz");
        flush = 1'b0;

        // Flush with hold still bubbles
        drive(1, 5'd3, 1, 5'd4, 1, 5'd12, 1, 0, 1, 0, 1, 4'd5);
        step("load_pre_fh");
        hold  = 1'b1;
        flush = 1'b1;
        drive(1, 5'd6, 1, 5'd7, 1, 5'd13, 1, 0, 0, 0, 0, 4'd6);
        step("flush_hold");
        flush = 1'b0;
        hold  = 1'b0;

        // Hold freezes contents while ID changes
        drive(1, 5'd8, 1, 5'd9, 1, 5'd14, 1, 0, 0, 0, 0, 4'd7);
        step("load_pre_hold");
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(i + 1), 1, 5'(i + 2), 1, 5'(i + 20), 1, 0, 1, 1, 1, 4'(i + 8));
            step($sformatf("hold_%0d", i));
        end
        hold = 1'b0;

        // Hold during a hazard: stall stays high, no bubble, no count
        drive(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 1, 1, 4'd2);
        step("lw_r5_c");
        drive(1, 5'd0, 0, 5'd5, 1, 5'd15, 1, 0, 0, 0, 0, 4'd3);
        hold = 1'b1;
        step("hold_hz_1");
        step("hold_hz_2");
        hold = 1'b0;
        step("hz_after_hold");
        step("add_after_hold");

        // r0 write suppression and invalid-instruction control masking
        drive(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 0, 0, 0, 4'd1);
        step("rw_r0");
        drive(0, 5'd1, 1, 5'd2, 1, 5'd3, 1, 1, 1, 1, 1, 4'd9);
        step("invalid_ctrl");

        // Saturation at all-ones
        @(negedge clk);
        force dut.stall_count_q = 16'hFFFF;
        #1 release dut.stall_count_q;
        m.count = 16'hFFFF;
        drive(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1, 0, 1, 1, 4'd2);
        step("sat_lw");
        drive(1, 5'd6, 1, 5'd0, 0, 5'd16, 1, 0, 0, 0, 0, 4'd3);
        step("sat_hz");

        // Asynchronous reset in the middle of a stall
        drive(1, 5'd1, 1, 5'd0, 0, 5'd4, 1, 1, 0, 1, 1, 4'd2);
        step("lw_r4");
        drive(1, 5'd4, 1, 5'd0, 0, 5'd17, 1, 0, 0, 0, 0, 4'd3);
        #1;
        check_bit("pre_rst_stall", stall, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_state", obs(), '0);
        check_bit("midrst_stall", stall, 1'b0);
        m = '0;
        #1 rst = 1'b0;
        drive(1, 5'd2, 1, 5'd3, 1, 5'd18, 1, 0, 0, 0, 0, 4'd1);
        step("post_rst_load");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
